// File: rtl/fifo_ctrl_v2_pkg.sv
// Shared constants and helpers for the fifo_ctrl_v2 FIFO family.
// Optional parity storage is enabled elsewhere with FIFO_PARITY_EN.
package fifo_pkg;

    localparam int FIFO_STD  = 0;
    localparam int FIFO_FWFT = 1;

    // Explicit wrap keeps non-power-of-two depths from aliasing.
    function automatic int unsigned fifo_ptr_inc(input int unsigned ptr, input int unsigned depth);
        return (ptr >= depth - 1) ? 0 : ptr + 1;
    endfunction

    function automatic int fifo_lvl_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/fifo_ctrl_v2_if.sv
// Producer/consumer bundle for fifo_ctrl_v2; LVL_W must equal fifo_lvl_w(DEPTH).
// parity_err is meaningful only when FIFO_PARITY_EN is defined.
interface fifo_ctrl_v2_if #(
    parameter int DATA_WIDTH = 32,
    parameter int LVL_W      = 5
);
    logic                  flush;
    logic                  wr_en;
    logic [DATA_WIDTH-1:0] data_in;
    logic                  rd_en;
    logic                  clr_err;
    logic [DATA_WIDTH-1:0] data_out;
    logic                  rd_valid;
    logic                  empty;
    logic                  full;
    logic                  almost_empty;
    logic                  almost_full;
    logic [LVL_W-1:0]      level;
    logic                  overflow;
    logic                  underflow;
    logic                  parity_err;

    modport master (
        output flush, wr_en, data_in, rd_en, clr_err,
        input  data_out, rd_valid, empty, full, almost_empty, almost_full,
               level, overflow, underflow, parity_err
    );

    modport slave (
        input  flush, wr_en, data_in, rd_en, clr_err,
        output data_out, rd_valid, empty, full, almost_empty, almost_full,
               level, overflow, underflow, parity_err
    );
endinterface

// File: rtl/fifo_ctrl_v2_mem.sv
// Storage array for fifo_ctrl_v2: one synchronous write port, one asynchronous read port.
// Width is widened by the top when FIFO_PARITY_EN is defined.
module fifo_mem #(
    parameter int WIDTH  = 32,
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WIDTH-1:0]  wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [WIDTH-1:0]  rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/fifo_ctrl_v2.sv
// Single-clock FIFO controller: any depth >= 2, standard or FWFT read, thresholds, flush, sticky errors.
// Define FIFO_PARITY_EN to store an even-parity bit per entry and flag mismatches on pop.
module fifo_ctrl_v2
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 16,
    parameter int FWFT       = FIFO_STD,
    parameter int AF_THRESH  = DEPTH - 2,
    parameter int AE_THRESH  = 2
) (
    input logic           clk,
    input logic           reset,
    fifo_ctrl_v2_if.slave bus
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = fifo_lvl_w(DEPTH);
`ifdef FIFO_PARITY_EN
    localparam int MEM_W = DATA_WIDTH + 1;
`else
    localparam int MEM_W = DATA_WIDTH;
`endif

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [LVL_W-1:0] level_q;
    logic [MEM_W-1:0] wdata;
    logic [MEM_W-1:0] rdata;
    logic             wr_acc;
    logic             rd_acc;
    logic             empty_i;
    logic             full_i;
    logic             overflow_q;
    logic             underflow_q;

    assign empty_i = (level_q == '0);
    assign full_i  = (level_q == LVL_W'(DEPTH));

    // Flush wins over both requests, so neither is accepted nor flagged as an error.
    assign rd_acc = bus.rd_en && !empty_i && !bus.flush;
    assign wr_acc = bus.wr_en && (!full_i || rd_acc) && !bus.flush;

`ifdef FIFO_PARITY_EN
    assign wdata = {^bus.data_in, bus.data_in};
`else
    assign wdata = bus.data_in;
`endif

    fifo_mem #(
        .WIDTH  (MEM_W),
        .DEPTH  (DEPTH),
        .ADDR_W (PTR_W)
    ) u_mem (
        .clk   (clk),
        .we    (wr_acc),
        .waddr (wr_ptr),
        .wdata (wdata),
        .raddr (rd_ptr),
        .rdata (rdata)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level_q <= '0;
        end else if (bus.flush) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level_q <= '0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= PTR_W'(fifo_ptr_inc(32'(wr_ptr), DEPTH));
            end
            if (rd_acc) begin
                rd_ptr <= PTR_W'(fifo_ptr_inc(32'(rd_ptr), DEPTH));
            end
            if (wr_acc && !rd_acc) begin
                level_q <= level_q + LVL_W'(1);
            end else if (rd_acc && !wr_acc) begin
                level_q <= level_q - LVL_W'(1);
            end
        end
    end

    // Set has priority over clr_err so a same-cycle error is never lost.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            overflow_q  <= (bus.wr_en && !wr_acc && !bus.flush) || (overflow_q && !bus.clr_err);
            underflow_q <= (bus.rd_en && !rd_acc && !bus.flush) || (underflow_q && !bus.clr_err);
        end
    end

    generate
        if (FWFT == FIFO_FWFT) begin : g_fwft
            assign bus.data_out = rdata[DATA_WIDTH-1:0];
            assign bus.rd_valid = !empty_i;
        end else begin : g_std
            logic [DATA_WIDTH-1:0] dout_q;
            logic                  rv_q;

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    dout_q <= '0;
                    rv_q   <= 1'b0;
                end else begin
                    rv_q <= rd_acc;
                    if (rd_acc) begin
                        dout_q <= rdata[DATA_WIDTH-1:0];
                    end
                end
            end

            assign bus.data_out = dout_q;
            assign bus.rd_valid = rv_q;
        end
    endgenerate

`ifdef FIFO_PARITY_EN
    logic parity_q;

    // Stored word includes its parity bit, so any odd reduction is a corruption.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            parity_q <= 1'b0;
        end else begin
            parity_q <= (rd_acc && (^rdata)) || (parity_q && !bus.clr_err);
        end
    end

    assign bus.parity_err = parity_q;
`else
    assign bus.parity_err = 1'b0;
`endif

    assign bus.level        = level_q;
    assign bus.empty        = empty_i;
    assign bus.full         = full_i;
    assign bus.almost_empty = (32'(level_q) <= AE_THRESH);
    assign bus.almost_full  = (32'(level_q) >= AF_THRESH);
    assign bus.overflow     = overflow_q;
    assign bus.underflow    = underflow_q;

endmodule

// File: tb/tb_fifo_ctrl_v2.sv
// Directed scoreboard bench for fifo_ctrl_v2: a DEPTH=5 standard-mode and a DEPTH=16 FWFT instance.
// Parity corruption steps run only when FIFO_PARITY_EN is defined.
module tb_fifo_ctrl_v2;
    import fifo_pkg::*;

    localparam int DW  = 8;
    localparam int DA  = 5;
    localparam int DB  = 16;
    localparam int LWA = fifo_lvl_w(DA);
    localparam int LWB = fifo_lvl_w(DB);

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    fifo_ctrl_v2_if #(.DATA_WIDTH(DW), .LVL_W(LWA)) ia ();
    fifo_ctrl_v2_if #(.DATA_WIDTH(DW), .LVL_W(LWB)) ib ();

    fifo_ctrl_v2 #(
        .DATA_WIDTH (DW),
        .DEPTH      (DA),
        .FWFT       (FIFO_STD)
    ) u_a (
        .clk   (clk),
        .reset (reset),
        .bus   (ia.slave)
    );

    fifo_ctrl_v2 #(
        .DATA_WIDTH (DW),
        .DEPTH      (DB),
        .FWFT       (FIFO_FWFT),
        .AF_THRESH  (14),
        .AE_THRESH  (2)
    ) u_b (
        .clk   (clk),
        .reset (reset),
        .bus   (ib.slave)
    );

    int            n_chk = 0;
    int            n_err = 0;
    logic [DW-1:0] sb_a[$];
    logic [DW-1:0] sb_b[$];
    int            lvl_a;
    int            lvl_b;
    logic          ovf_a;
    logic          unf_a;
    logic [DW-1:0] last_a;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cyc_a(input logic we, input logic [DW-1:0] d, input logic re,
                         input logic clr, input string tag);
        logic          ra;
        logic          wa;
        logic [DW-1:0] exp_d;
        ra = re && (lvl_a != 0);
        wa = we && ((lvl_a != DA) || ra);
        ia.wr_en   = we;
        ia.data_in = d;
        ia.rd_en   = re;
        ia.clr_err = clr;
        tick();
        ia.wr_en   = 1'b0;
        ia.rd_en   = 1'b0;
        ia.clr_err = 1'b0;
        ovf_a = (we && !wa) || (ovf_a && !clr);
        unf_a = (re && !ra) || (unf_a && !clr);
        exp_d = last_a;
        if (ra) begin
            exp_d  = sb_a.pop_front();
            last_a = exp_d;
        end
        if (wa) sb_a.push_back(d);
        lvl_a = lvl_a + int'(wa) - int'(ra);
        chk({tag, "_valid"}, 32'(ia.rd_valid), 32'(ra));
        chk({tag, "_data"},  32'(ia.data_out), 32'(exp_d));
        chk({tag, "_level"}, 32'(ia.level), lvl_a);
        chk({tag, "_ovf"},   32'(ia.overflow), 32'(ovf_a));
        chk({tag, "_unf"},   32'(ia.underflow), 32'(unf_a));
        chk({tag, "_empty"}, 32'(ia.empty), 32'(lvl_a == 0));
        chk({tag, "_full"},  32'(ia.full), 32'(lvl_a == DA));
    endtask

    task automatic cyc_b(input logic we, input logic [DW-1:0] d, input logic re, input string tag);
        logic          ra;
        logic          wa;
        logic [DW-1:0] tmp;
        ra = re && (lvl_b != 0);
        wa = we && ((lvl_b != DB) || ra);
        ib.wr_en   = we;
        ib.data_in = d;
        ib.rd_en   = re;
        tick();
        ib.wr_en = 1'b0;
        ib.rd_en = 1'b0;
        if (ra) tmp = sb_b.pop_front();
        if (wa) sb_b.push_back(d);
        lvl_b = lvl_b + int'(wa) - int'(ra);
        chk({tag, "_level"}, 32'(ib.level), lvl_b);
        chk({tag, "_empty"}, 32'(ib.empty), 32'(lvl_b == 0));
        chk({tag, "_valid"}, 32'(ib.rd_valid), 32'(lvl_b != 0));
        chk({tag, "_ae"},    32'(ib.almost_empty), 32'(lvl_b <= 2));
        chk({tag, "_af"},    32'(ib.almost_full), 32'(lvl_b >= 14));
        if (lvl_b != 0) chk({tag, "_head"}, 32'(ib.data_out), 32'(sb_b[0]));
    endtask

    initial begin : main
        int   wcnt;
        int   n;
        logic saw_full;
        logic we;
        logic re;

        reset = 1'b1;
        ia.flush = 1'b0; ia.wr_en = 1'b0; ia.data_in = '0; ia.rd_en = 1'b0; ia.clr_err = 1'b0;
        ib.flush = 1'b0; ib.wr_en = 1'b0; ib.data_in = '0; ib.rd_en = 1'b0; ib.clr_err = 1'b0;
        lvl_a = 0; lvl_b = 0; ovf_a = 1'b0; unf_a = 1'b0; last_a = '0;
        repeat (2) @(posedge clk);
        #3 reset = 1'b0;
        #1;

        chk("rst_level",  32'(ia.level), 0);
        chk("rst_empty",  32'(ia.empty), 1);
        chk("rst_full",   32'(ia.full), 0);
        chk("rst_ae",     32'(ia.almost_empty), 1);
        chk("rst_af",     32'(ia.almost_full), 0);
        chk("rst_dout",   32'(ia.data_out), 0);
        chk("rst_valid",  32'(ia.rd_valid), 0);
        chk("rst_ovf",    32'(ia.overflow), 0);
        chk("rst_unf",    32'(ia.underflow), 0);
        chk("rst_par",    32'(ia.parity_err), 0);
        chk("rst_b_empty", 32'(ib.empty), 1);
        chk("rst_b_valid", 32'(ib.rd_valid), 0);
        chk("rst_b_af",    32'(ib.almost_full), 0);

        // Fill, overflow, drain in order.
        for (int i = 1; i <= 5; i++) cyc_a(1'b1, DW'(i), 1'b0, 1'b0, "fill");
        cyc_a(1'b1, 8'h06, 1'b0, 1'b0, "ovf");
        for (int i = 0; i < 5; i++) cyc_a(1'b0, '0, 1'b1, 1'b0, "drain");
        cyc_a(1'b0, '0, 1'b0, 1'b0, "idle");

        // Underflow set in the same cycle as clr_err: overflow clears, underflow sets.
        cyc_a(1'b0, '0, 1'b1, 1'b1, "unf_clr");
        cyc_a(1'b1, 8'h77, 1'b1, 1'b0, "empty_rw");
        cyc_a(1'b0, '0, 1'b1, 1'b1, "empty_rw_rd");

        // Two writes per read across pointer wrap; producer honours full.
        wcnt = 0; n = 0; saw_full = 1'b0;
        while (((wcnt < 12) || (lvl_a != 0)) && (n < 100)) begin
            re = (n % 2 == 1) || (wcnt >= 12);
            we = (wcnt < 12) && ((lvl_a < DA) || re);
            cyc_a(we, DW'(wcnt + 1), re, 1'b0, "stream");
            if (we) wcnt++;
            if (ia.full) saw_full = 1'b1;
            n++;
        end
        chk("stream_full_seen", 32'(saw_full), 1);
        chk("stream_bound", 32'(n < 100), 1);

        // Full with simultaneous read and write.
        for (int i = 0; i < 5; i++) cyc_a(1'b1, DW'(8'h20 + i), 1'b0, 1'b0, "refill");
        cyc_a(1'b1, 8'h30, 1'b1, 1'b0, "full_rw");

        // Flush while full with write and read requested.
        ia.flush = 1'b1; ia.wr_en = 1'b1; ia.data_in = 8'hEE; ia.rd_en = 1'b1;
        tick();
        ia.flush = 1'b0; ia.wr_en = 1'b0; ia.rd_en = 1'b0;
        sb_a.delete(); lvl_a = 0;
        chk("flush_level", 32'(ia.level), 0);
        chk("flush_empty", 32'(ia.empty), 1);
        chk("flush_valid", 32'(ia.rd_valid), 0);
        chk("flush_dout",  32'(ia.data_out), 32'(last_a));
        chk("flush_ovf",   32'(ia.overflow), 0);
        chk("flush_unf",   32'(ia.underflow), 0);
        cyc_a(1'b1, 8'h55, 1'b0, 1'b0, "post_flush_wr");
        cyc_a(1'b0, '0, 1'b1, 1'b0, "post_flush_rd");
        chk("par_clean", 32'(ia.parity_err), 0);

        // FWFT instance.
        cyc_b(1'b1, 8'hA5, 1'b0, "fwft_wr");
        chk("fwft_dout", 32'(ib.data_out), 32'h0000_00A5);
        cyc_b(1'b0, '0, 1'b1, "fwft_pop");
        for (int i = 1; i <= 16; i++) cyc_b(1'b1, DW'(8'h80 + i), 1'b0, "thr");
        for (int i = 0; i < 4; i++) cyc_b(1'b0, '0, 1'b1, "fwft_drain");
        cyc_b(1'b1, 8'hC3, 1'b1, "fwft_rw");
        ib.flush = 1'b1; ib.wr_en = 1'b1; ib.data_in = 8'hEE; ib.rd_en = 1'b1;
        tick();
        ib.flush = 1'b0; ib.wr_en = 1'b0; ib.rd_en = 1'b0;
        sb_b.delete(); lvl_b = 0;
        chk("b_flush_level", 32'(ib.level), 0);
        chk("b_flush_empty", 32'(ib.empty), 1);
        chk("b_flush_valid", 32'(ib.rd_valid), 0);
        chk("b_flush_ovf",   32'(ib.overflow), 0);
        chk("b_flush_unf",   32'(ib.underflow), 0);
        cyc_b(1'b1, 8'h5A, 1'b0, "b_post_flush");
        cyc_b(1'b0, '0, 1'b1, "b_post_pop");

        // Asynchronous reset in the middle of a read pulse with overflow set.
        for (int i = 0; i < 5; i++) cyc_a(1'b1, DW'(8'h40 + i), 1'b0, 1'b0, "pre_rst");
        cyc_a(1'b1, 8'h99, 1'b0, 1'b0, "pre_rst_ovf");
        cyc_a(1'b0, '0, 1'b1, 1'b0, "pre_rst_rd");
        #2 reset = 1'b1;
        #1;
        chk("arst_valid", 32'(ia.rd_valid), 0);
        chk("arst_dout",  32'(ia.data_out), 0);
        chk("arst_level", 32'(ia.level), 0);
        chk("arst_empty", 32'(ia.empty), 1);
        chk("arst_full",  32'(ia.full), 0);
        chk("arst_ovf",   32'(ia.overflow), 0);
        chk("arst_b_level", 32'(ib.level), 0);
        @(posedge clk);
        #2 reset = 1'b0;
        sb_a.delete(); sb_b.delete();
        lvl_a = 0; lvl_b = 0; ovf_a = 1'b0; unf_a = 1'b0; last_a = '0;
        cyc_a(1'b1, 8'h3C, 1'b0, 1'b0, "post_rst_wr");

`ifdef FIFO_PARITY_EN
        u_a.u_mem.mem[0] = u_a.u_mem.mem[0] ^ 9'h001;
        sb_a[0] = 8'h3D;
        cyc_a(1'b0, '0, 1'b1, 1'b0, "par_rd");
        chk("par_set", 32'(ia.parity_err), 1);
        cyc_a(1'b0, '0, 1'b0, 1'b0, "par_hold");
        chk("par_sticky", 32'(ia.parity_err), 1);
        cyc_a(1'b0, '0, 1'b0, 1'b1, "par_clr");
        chk("par_cleared", 32'(ia.parity_err), 0);
`else
        cyc_a(1'b0, '0, 1'b1, 1'b0, "post_rst_rd");
        chk("par_zero", 32'(ia.parity_err), 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/fifo_ctrl_v2.md
Name: fifo_ctrl_v2

Overview:
Parametrised synchronous single-clock FIFO. It is the next generation of the team's basic FIFO and adds the following:
- non-power-of-two depth
- selectable standard or first-word-fall-through (FWFT) read mode
- programmable almost-full and almost-empty flags
- a fill-level output
- synchronous flush
- sticky overflow and underflow error flags

It sits between producer and consumer pipeline stages in the same clock domain.

Parameters:
DATA_WIDTH, 32, width of each stored word.
DEPTH, 16, number of entries; any integer >= 2, not required to be a power of two.
FWFT, 0, read mode: 0 = standard (registered read, 1-cycle latency), 1 = first-word-fall-through.
AF_THRESH, DEPTH-2, almost_full asserts when level >= AF_THRESH.
AE_THRESH, 2, almost_empty asserts when level <= AE_THRESH.

Ports:
clk  input  1  clock, rising edge.
reset  input  1  asynchronous, active-high reset.
flush  input  1  synchronous clear of contents.
wr_en  input  1  write request.
data_in  input  DATA_WIDTH  write data.
rd_en  input  1  read (pop) request.
data_out  output  DATA_WIDTH  read data.
rd_valid  output  1  data_out holds valid popped/head data.
empty  output  1  level == 0.
full  output  1  level == DEPTH.
almost_empty  output  1  level <= AE_THRESH.
almost_full  output  1  level >= AF_THRESH.
level  output  $clog2(DEPTH+1)  current occupancy.
overflow  output  1  sticky: a write was rejected.
underflow  output  1  sticky: a read was rejected.
clr_err  input  1  synchronous clear of overflow, underflow and parity_err.
parity_err  output  1  sticky parity error; tied 0 when FIFO_PARITY_EN is undefined.

Behaviour:
- Clocking and reset: one clock, clk. reset is asynchronous and active-high.
- Reset values: wr_ptr=0, rd_ptr=0, level=0, data_out=0, rd_valid=0, overflow=0, underflow=0, parity_err=0. Flag values follow from level: empty=1, full=0, almost_empty=1, almost_full=(AF_THRESH==0).
- Pointers: width $clog2(DEPTH). Each increments by 1 and wraps from DEPTH-1 to 0 explicitly; no power-of-two aliasing.
- Write acceptance: wr_acc = wr_en && (!full || rd_acc). A write to a full FIFO is accepted when a read is accepted in the same cycle.
- Read acceptance: rd_acc = rd_en && !empty. A read on an empty FIFO is rejected even if a write occurs the same cycle.
- Level update: level += wr_acc - rd_acc. Simultaneous accepted read and write leaves level unchanged.
- Flags: all derived combinationally from the level register; they change the cycle after the causing edge.
- Standard mode (FWFT=0):
  - On rd_acc, data_out <= mem[rd_ptr] at the edge and rd_valid=1 for exactly the following cycle.
  - Otherwise data_out holds its value and rd_valid=0.
- FWFT mode (FWFT=1):
  - data_out = mem[rd_ptr] combinationally; rd_valid = !empty.
  - rd_en pops the head word. A written word is visible the cycle after its write edge.
- Error flags:
  - overflow sets on wr_en && !wr_acc; underflow sets on rd_en && !rd_acc.
  - Both stay set until clr_err. If a set condition and clr_err occur in the same cycle, the flag is set (set wins).
- Flush:
  - Clears wr_ptr, rd_ptr and level at the next edge. Has priority over wr_en/rd_en in that cycle; neither request is accepted and no error flag sets.
  - data_out is unchanged in standard mode. rd_valid=0 in the cycle after flush.
- Reset mid-operation: immediate asynchronous return to reset values; memory contents are don't-care.

Optional Feature:
Macro FIFO_PARITY_EN.
- Defined:
  - Each entry stores DATA_WIDTH+1 bits; the extra bit is the even parity of data_in, computed at write.
  - On each rd_acc (standard mode) or head pop (FWFT mode), parity is recomputed; a mismatch sets parity_err (sticky, cleared by clr_err).
- Undefined: no extra storage; parity_err is constant 0.

Decomposition:
- Package fifo_pkg:
  - FIFO_STD=0 and FIFO_FWFT=1 mode constants.
  - Function fifo_ptr_inc(ptr, depth) returning the wrapped increment.
  - Function fifo_lvl_w(depth) returning $clog2(depth+1).
- Sub-module fifo_mem: simple dual-port register array with one write port and an asynchronous read port. It is instantiated once; width is DATA_WIDTH (+1 under FIFO_PARITY_EN). All pointer, level and flag logic stays in fifo_ctrl_v2.

Test Plan:
- Wrap-around and ordering: DEPTH=5, FWFT=0. Write 0x1..0x5 → full=1, level=5. Write 0x6 → overflow=1, level stays 5. Read 5 times → data_out 0x1..0x5, each with a 1-cycle rd_valid pulse. Then empty=1.
- Wrap-around under load: DEPTH=5. Stream 12 words with 2 writes per read → read order is exactly 1..12 across pointer wrap; full reached with no data loss.
- Simultaneous read/write: full FIFO (level=DEPTH), wr_en and rd_en together → both accepted, level unchanged, no overflow. Empty FIFO, both together → write accepted, read rejected, underflow=1, level=1.
- FWFT: FWFT=1. Write 0xA5 → the next cycle data_out=0xA5, rd_valid=1, empty=0. Assert rd_en → the following cycle empty=1, rd_valid=0.
- Thresholds, flush and clear:
  - DEPTH=16, AF_THRESH=14, AE_THRESH=2. level 2→3 deasserts almost_empty; level 14 asserts almost_full.
  - flush with wr_en=1 → next cycle level=0, empty=1, no write stored.
  - clr_err clears overflow.
- Reset mid-stream and parity: assert reset mid-burst → outputs return to reset values the same cycle. With FIFO_PARITY_EN defined, force-flip a stored bit, then read it → parity_err=1 until clr_err.
